// File: rtl/square_pkg.sv
// Shared definitions for the square sprite controllers: FSM states, register
// indices, default screen geometry and the origin clamp used on writes.
package square_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_X0   = 3'd1;
  localparam logic [2:0] REG_Y0   = 3'd2;
  localparam logic [2:0] REG_DX   = 3'd3;
  localparam logic [2:0] REG_DY   = 3'd4;
  localparam logic [2:0] REG_DIV  = 3'd5;
  localparam logic [2:0] REG_BCNT = 3'd6;

  localparam int H_MAX_DEF = 640;
  localparam int V_MAX_DEF = 480;
  localparam int SIZE_DEF  = 16;
  localparam int VW_DEF    = 4;
  localparam int COORD_W   = 11;

  // Software writes a signed 32-bit origin; keep it fully on screen.
  function automatic logic [COORD_W-1:0] clamp_origin(input logic [31:0] data,
                                                      input int lim);
    if ($signed(data) < 0)        return '0;
    else if ($signed(data) > lim) return COORD_W'(lim);
    else                          return data[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-start detector shared by sprite controllers: pulses for one cycle
// when the scan steps from x=0 to x=1 on line 0.
module frame_tick_gen
  import square_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               frame_tick
);

  logic [COORD_W-1:0] x_d1;

  // Previous scan column, used to see the 0 -> 1 step.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) x_d1 <= '0;
    else          x_d1 <= x;
  end

  assign frame_tick = (x_d1 == '0) && (x == COORD_W'(1)) && (y == '0);

endmodule

// File: rtl/square_motion_ctrl.sv
// Square sprite motion controller: owns the sprite origin, moves it by a
// signed per-frame velocity, bounces off the screen edges and exposes a small
// register port. The origin only changes on the frame-start tick.
module square_motion_ctrl
  import square_pkg::*;
#(
  parameter int H_MAX = H_MAX_DEF,
  parameter int V_MAX = V_MAX_DEF,
  parameter int SIZE  = SIZE_DEF,
  parameter int VW    = VW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [2:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic               frame_tick,
  output logic               hit
);

  localparam int X_MAX = H_MAX - SIZE;
  localparam int Y_MAX = V_MAX - SIZE;
  localparam logic signed [COORD_W:0] X_LIM = (COORD_W+1)'(X_MAX);
  localparam logic signed [COORD_W:0] Y_LIM = (COORD_W+1)'(Y_MAX);

  state_t                    state, state_nxt;
  logic                      run;
  logic signed [VW-1:0]      dx, dy;
  logic [7:0]                div, fcnt;
  logic [COORD_W-1:0]        pend_x, pend_y;
  logic                      pend_x_vld, pend_y_vld, pend_vld;
  logic [15:0]               bounce_cnt;
  logic                      step_req, move_en, fcnt_adv;
  logic signed [COORD_W:0]   nx, ny;
  logic [COORD_W-1:0]        mx, my;
  logic                      bx, by;

  // The most negative velocity has no positive twin; reflect it to the largest positive one.
  function automatic logic signed [VW-1:0] sat_neg(input logic signed [VW-1:0] v);
    if (v == {1'b1, {(VW-1){1'b0}}}) return {1'b0, {(VW-1){1'b1}}};
    return -v;
  endfunction

  frame_tick_gen u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick)
  );

  assign pend_vld = pend_x_vld | pend_y_vld;
  assign step_req = wr_en && (wr_addr == REG_CTRL) && wr_data[1];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: stopping and single steps resolve on the frame tick.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run)           state_nxt = RUN;
        else if (step_req) state_nxt = STEP;
      end
      RUN:     if (frame_tick && !run)      state_nxt = IDLE;
      STEP:    if (frame_tick && !pend_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: a pending origin load consumes the tick, so no move and no count.
  always_comb begin
    fcnt_adv = 1'b0;
    move_en  = 1'b0;
    case (state)
      RUN: begin
        fcnt_adv = frame_tick && run && !pend_vld;
        move_en  = fcnt_adv && (fcnt == div);
      end
      STEP:    move_en = frame_tick && !pend_vld;
      default: ;
    endcase
  end

  // Frame divider: counts ticks in RUN, restarts whenever RUN is re-entered.
  always_ff @(posedge clk) begin
    if (!reset_n)           fcnt <= '0;
    else if (state != RUN)  fcnt <= '0;
    else if (fcnt_adv)      fcnt <= (fcnt == div) ? 8'd0 : fcnt + 8'd1;
  end

  // Axis datapaths: candidate origin in one extra signed bit, clipped to the edges.
  always_comb begin
    nx = $signed({1'b0, x0}) + $signed({{(COORD_W+1-VW){dx[VW-1]}}, dx});
    ny = $signed({1'b0, y0}) + $signed({{(COORD_W+1-VW){dy[VW-1]}}, dy});
    mx = nx[COORD_W-1:0];
    my = ny[COORD_W-1:0];
    bx = 1'b0;
    by = 1'b0;
    if (nx < 0) begin
      mx = '0;
      bx = 1'b1;
    end else if (nx > X_LIM) begin
      mx = X_LIM[COORD_W-1:0];
      bx = 1'b1;
    end
    if (ny < 0) begin
      my = '0;
      by = 1'b1;
    end else if (ny > Y_LIM) begin
      my = Y_LIM[COORD_W-1:0];
      by = 1'b1;
    end
  end

  // Origin, velocity and register file updates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x0         <= '0;
      y0         <= '0;
      dx         <= VW'(1);
      dy         <= VW'(1);
      div        <= '0;
      run        <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_x_vld <= 1'b0;
      pend_y_vld <= 1'b0;
      hit        <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      hit <= 1'b0;
      if (frame_tick) begin
        if (pend_vld) begin
          if (pend_x_vld) x0 <= pend_x;
          if (pend_y_vld) y0 <= pend_y;
          pend_x_vld <= 1'b0;
          pend_y_vld <= 1'b0;
        end else if (move_en) begin
          x0 <= mx;
          y0 <= my;
          if (bx) dx <= sat_neg(dx);
          if (by) dy <= sat_neg(dy);
          if (bx || by) begin
            hit <= 1'b1;
            if (bounce_cnt != 16'hFFFF) bounce_cnt <= bounce_cnt + 16'd1;
          end
        end
      end
      // NOTE: register writes come last so they override the tick updates above
      // (a tick-cycle write stays pending; a software velocity beats a bounce flip).
      if (wr_en) begin
        case (wr_addr)
          REG_CTRL: run <= wr_data[0];
          REG_X0: begin
            pend_x     <= clamp_origin(wr_data, X_MAX);
            pend_x_vld <= 1'b1;
          end
          REG_Y0: begin
            pend_y     <= clamp_origin(wr_data, Y_MAX);
            pend_y_vld <= 1'b1;
          end
          REG_DX:  dx  <= wr_data[VW-1:0];
          REG_DY:  dy  <= wr_data[VW-1:0];
          REG_DIV: div <= wr_data[7:0];
          default: ;
        endcase
      end
    end
  end

  // Combinational register read.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_CTRL: rd_data = {29'd0, state, run};
      REG_X0:   rd_data = {{(32-COORD_W){1'b0}}, x0};
      REG_Y0:   rd_data = {{(32-COORD_W){1'b0}}, y0};
      REG_BCNT: rd_data = {16'd0, bounce_cnt};
      default:  rd_data = '0;
    endcase
  end

endmodule
